muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU from EX and sequences a one-bit-per-cycle shift-add multiplier or restoring divider. It owns the HI/LO registers and raises a pipeline stall when an instruction touches HI/LO while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: op codes, FSM states
// and the divide-by-zero quotient pattern.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide step.
// Purely combinational; the sequencer registers the outputs once per cycle.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
  assign w_shl  = {i_acc, i_q[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, i_b};

  // Remainder stays below the divisor, so a borrow implies w_shl fits in WIDTH bits.
  always_comb begin
    o_acc = w_sum[WIDTH:1];
    o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    if (i_is_div) begin
      if (w_diff[WIDTH]) begin
        o_acc = w_shl[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = w_diff[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; result lands WIDTH+1 edges after start.
// While busy, any start/MFHI/MFLO/MTHI/MTLO raises stall and is dropped for EX to re-present.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_hilo_rd,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div0;
  logic             r_busy;
  logic             r_done;

  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg  = w_signed && i_src_a[WIDTH-1];
  assign w_b_neg  = w_signed && i_src_b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -i_src_a : i_src_a;
  assign w_b_abs  = w_b_neg ? -i_src_b : i_src_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_acc_nxt),
    .o_q      (w_q_nxt)
  );

  // Divide by zero leaves the dividend magnitude in r_acc, so the remainder
  // sign fixup reproduces the raw dividend in HI.
  assign w_prod_raw = {r_acc, r_q};
  assign w_prod_fix = r_sign_q ? -w_prod_raw : w_prod_raw;

  always_comb begin
    w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      w_hi_fix = r_sign_r ? -r_acc : r_acc;
      if (r_div0) begin
        w_lo_fix = DIV0_LO[WIDTH-1:0];
      end else begin
        w_lo_fix = r_sign_q ? -r_q : r_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_hi_we) r_hi <= i_wdata;
        if (i_lo_we) r_lo <= i_wdata;
      end
      case (r_state)
        IDLE: begin
          if (i_start && !i_flush) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_div0   <= w_is_div && (i_src_b == '0);
            r_acc    <= '0;
            r_q      <= w_is_div ? w_a_abs : w_b_abs;
            r_b      <= w_is_div ? w_b_abs : w_a_abs;
          end
        end
        RUN: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_stall = r_busy && (i_start || i_hilo_rd || i_hi_we || i_lo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, arithmetic corner cases, stall, flush, reset.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_rd;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_op      (op),
    .i_src_a   (src_a),
    .i_src_b   (src_b),
    .i_hilo_rd (hilo_rd),
    .i_hi_we   (hi_we),
    .i_lo_we   (lo_we),
    .i_wdata   (wdata),
    .i_flush   (flush),
    .o_hi      (hi),
    .o_lo      (lo),
    .o_busy    (busy),
    .o_done    (done),
    .o_stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single edge, then waits (bounded) for done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    n_checks++;
    if ({busy, done, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, stall}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult_latency;
    int bad_busy;
    bad_busy = 0;
    op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k <= 32 && {busy, done} !== 2'b10) bad_busy++;
      if (k == 33) begin
        n_checks++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL mult_done_edge: got busy,done=%b want 01", {busy, done}); end
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h want ffffffffffffffeb", {hi, lo}); end
      end
      if (k == 34) begin
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
      end
    end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL mult_busy_window: got %0d bad cycles want 0", bad_busy); end
  endtask

  task automatic test_vectors;
    logic [1:0]  v_op [9];
    logic [31:0] v_a  [9];
    logic [31:0] v_b  [9];
    logic [63:0] v_hl [9];
    int lat;
    v_op[0] = 2'b01; v_a[0] = 32'hFFFF_FFFF; v_b[0] = 32'hFFFF_FFFF; v_hl[0] = 64'hFFFF_FFFE_0000_0001;
    v_op[1] = 2'b10; v_a[1] = 32'hFFFF_FFF9; v_b[1] = 32'd2;        v_hl[1] = 64'hFFFF_FFFF_FFFF_FFFD;
    v_op[2] = 2'b11; v_a[2] = 32'd100;       v_b[2] = 32'd0;        v_hl[2] = 64'h0000_0064_FFFF_FFFF;
    v_op[3] = 2'b10; v_a[3] = 32'h8000_0000; v_b[3] = 32'hFFFF_FFFF; v_hl[3] = 64'h0000_0000_8000_0000;
    v_op[4] = 2'b00; v_a[4] = 32'd0;         v_b[4] = 32'hFFFF_FFFB; v_hl[4] = 64'h0;
    v_op[5] = 2'b10; v_a[5] = 32'hFFFF_FFF9; v_b[5] = 32'd0;        v_hl[5] = 64'hFFFF_FFF9_FFFF_FFFF;
    v_op[6] = 2'b11; v_a[6] = 32'd100;       v_b[6] = 32'd7;        v_hl[6] = 64'h0000_0002_0000_000E;
    v_op[7] = 2'b10; v_a[7] = 32'd7;         v_b[7] = 32'hFFFF_FFFE; v_hl[7] = 64'h0000_0001_FFFF_FFFD;
    v_op[8] = 2'b00; v_a[8] = 32'hFFFF_FFFC; v_b[8] = 32'hFFFF_FFFB; v_hl[8] = 64'h0000_0000_0000_0014;
    for (int i = 0; i < 9; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], lat);
      n_checks++;
      if (lat != 33) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 33", i, lat); end
      n_checks++;
      if ({hi, lo} !== v_hl[i]) begin n_fail++; $display("FAIL vec%0d_result: got %h want %h", i, {hi, lo}, v_hl[i]); end
    end
  endtask

  task automatic test_stall;
    int bad_stall;
    bad_stall = 0;
    hi_we = 1'b1; wdata = 32'h1111;
    tick();
    hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'h1111) begin n_fail++; $display("FAIL mthi_idle: got %h want 00001111", hi); end
    op = 2'b01; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k >= 5 && k <= 32 && stall !== 1'b1) bad_stall++;
      if (k == 4) hilo_rd = 1'b1;
      if (k == 10) begin
        op = 2'b11; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_on_start: got %b want 1", stall); end
      end
      if (k == 11) start = 1'b0;
      if (k == 12) begin hi_we = 1'b1; wdata = 32'hDEAD; end
      if (k == 13) begin
        hi_we = 1'b0;
        n_checks++;
        if (hi !== 32'h1111) begin n_fail++; $display("FAIL mthi_busy_ignored: got %h want 00001111", hi); end
      end
      if (k == 33) begin
        n_checks++;
        if ({stall, done} !== 2'b01) begin n_fail++; $display("FAIL stall_release: got stall,done=%b want 01", {stall, done}); end
        n_checks++;
        if ({hi, lo} !== 64'd30) begin n_fail++; $display("FAIL multu_5x6: got %h want 30", {hi, lo}); end
      end
    end
    hilo_rd = 1'b0;
    n_checks++;
    if (bad_stall != 0) begin n_fail++; $display("FAIL stall_window: got %0d bad cycles want 0", bad_stall); end
  endtask

  task automatic test_flush;
    int n_done;
    lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    op = 2'b10; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", n_done); end
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_1234) begin n_fail++; $display("FAIL flush_hilo_kept: got %h want 0000000000001234", {hi, lo}); end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_same_cycle: got busy %b want 0", busy); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++;
    if ({hi, lo} !== 64'h0000_ABCD_0000_ABCD) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h want 0000abcd0000abcd", {hi, lo}); end
  endtask

  task automatic test_start_with_mt;
    int lat;
    op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    tick();
    start = 1'b0; lo_we = 1'b0;
    n_checks++;
    if ({busy, lo} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL start_mt_same_edge: got busy %b lo %h want 1 00000055", busy, lo); end
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    n_checks++;
    if ({hi, lo} !== 64'd6) begin n_fail++; $display("FAIL start_mt_overwrite: got %h want 6 (lat %0d)", {hi, lo}, lat); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    hi_we = 1'b1; wdata = 32'h77;
    tick();
    hi_we = 1'b0;
    op = 2'b00; src_a = 32'd16; src_b = 32'd16; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({hi, lo, busy, done} !== 66'h0) begin n_fail++; $display("FAIL reset_mid_op: got hi %h lo %h busy %b done %b want all 0", hi, lo, busy, done); end
    rst_n = 1'b1;
    do_op(2'b00, 32'd2, 32'd3, lat);
    n_checks++;
    if ({hi, lo} !== 64'd6 || lat != 33) begin n_fail++; $display("FAIL mult_after_reset: got %h lat %0d want 6 lat 33", {hi, lo}, lat); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    test_reset();
    test_mult_latency();
    test_vectors();
    test_stall();
    test_flush();
    test_start_with_mt();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
